// File: rtl/riscv_decode_stage.sv
// RV32I instruction-decode stage: one registered slot between fetch and execute.
// Drives register-file read addresses alongside the decoded rd/immediate/opcode fields.
module riscv_decode_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  if_valid,
  output logic                  if_ready,
  input  logic [XLEN-1:0]       if_instr,
  input  logic [XLEN-1:0]       if_pc,
  output logic [REG_ADDR_W-1:0] rs1,
  output logic [REG_ADDR_W-1:0] rs2,
  output logic                  id_valid,
  input  logic                  id_ready,
  output logic [XLEN-1:0]       id_pc,
  output logic [6:0]            id_opcode,
  output logic [2:0]            id_funct3,
  output logic                  id_funct7b5,
  output logic [REG_ADDR_W-1:0] id_rd,
  output logic                  id_rd_we,
  output logic [XLEN-1:0]       id_imm,
  output logic                  id_illegal
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_MISC   = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [6:0]            opcode;
  logic [REG_ADDR_W-1:0] f_rs1, f_rs2, f_rd;
  logic                  legal, use_rs1, use_rs2, writes_rd;
  logic [XLEN-1:0]       imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0]       d_imm;
  logic [REG_ADDR_W-1:0] d_rs1, d_rs2, d_rd;
  logic                  d_rd_we;
  logic                  load;

  assign opcode = if_instr[6:0];
  assign f_rd   = if_instr[7 +: REG_ADDR_W];
  assign f_rs1  = if_instr[15 +: REG_ADDR_W];
  assign f_rs2  = if_instr[20 +: REG_ADDR_W];

  assign imm_i = {{(XLEN-12){if_instr[31]}}, if_instr[31:20]};
  assign imm_s = {{(XLEN-12){if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
  assign imm_b = {{(XLEN-13){if_instr[31]}}, if_instr[31], if_instr[7],
                  if_instr[30:25], if_instr[11:8], 1'b0};
  assign imm_u = {{(XLEN-32){if_instr[31]}}, if_instr[31:12], 12'b0};
  assign imm_j = {{(XLEN-21){if_instr[31]}}, if_instr[31], if_instr[19:12],
                  if_instr[20], if_instr[30:21], 1'b0};

  // Every legal opcode ends in 2'b11, so the opcode match also covers the
  // compressed-encoding check.
  always_comb begin
    legal     = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    writes_rd = 1'b0;
    d_imm     = '0;
    case (opcode)
      OP_LUI:    begin legal = 1'b1; writes_rd = 1'b1; d_imm = imm_u; end
      OP_AUIPC:  begin legal = 1'b1; writes_rd = 1'b1; d_imm = imm_u; end
      OP_JAL:    begin legal = 1'b1; writes_rd = 1'b1; d_imm = imm_j; end
      OP_JALR:   begin legal = 1'b1; writes_rd = 1'b1; use_rs1 = 1'b1; d_imm = imm_i; end
      OP_BRANCH: begin legal = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; d_imm = imm_b; end
      OP_LOAD:   begin legal = 1'b1; writes_rd = 1'b1; use_rs1 = 1'b1; d_imm = imm_i; end
      OP_STORE:  begin legal = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; d_imm = imm_s; end
      OP_IMM:    begin legal = 1'b1; writes_rd = 1'b1; use_rs1 = 1'b1; d_imm = imm_i; end
      OP_OP:     begin legal = 1'b1; writes_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OP_MISC:   begin legal = 1'b1; d_imm = imm_i; end
      OP_SYSTEM: begin legal = 1'b1; d_imm = imm_i; end
      default:   begin legal = 1'b0; end
    endcase
  end

  assign d_rd_we = writes_rd && (f_rd != '0);
  assign d_rd    = d_rd_we ? f_rd : '0;
  assign d_rs1   = use_rs1 ? f_rs1 : '0;
  assign d_rs2   = use_rs2 ? f_rs2 : '0;

  assign if_ready = (!id_valid || id_ready) && !flush;
  assign load     = if_valid && if_ready;

  // Flush only clears the read addresses so the register file stops
  // advertising stale sources; other fields just go invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid    <= 1'b0;
      rs1         <= '0;
      rs2         <= '0;
      id_pc       <= '0;
      id_opcode   <= '0;
      id_funct3   <= '0;
      id_funct7b5 <= 1'b0;
      id_rd       <= '0;
      id_rd_we    <= 1'b0;
      id_imm      <= '0;
      id_illegal  <= 1'b0;
    end else if (flush) begin
      id_valid <= 1'b0;
      rs1      <= '0;
      rs2      <= '0;
    end else if (load) begin
      id_valid    <= 1'b1;
      rs1         <= d_rs1;
      rs2         <= d_rs2;
      id_pc       <= if_pc;
      id_opcode   <= opcode;
      id_funct3   <= if_instr[14:12];
      id_funct7b5 <= if_instr[30];
      id_rd       <= d_rd;
      id_rd_we    <= d_rd_we;
      id_imm      <= d_imm;
      id_illegal  <= !legal;
    end else if (id_valid && id_ready) begin
      id_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_riscv_decode_stage.sv
// Directed bench for riscv_decode_stage: table of hand-decoded instructions
// streamed back-to-back, plus stall, flush and reset sequences.
module tb_riscv_decode_stage;

  logic        clk = 1'b0;
  logic        rst, flush, if_valid, if_ready, id_valid, id_ready;
  logic [31:0] if_instr, if_pc, id_pc, id_imm;
  logic [4:0]  rs1, rs2, id_rd;
  logic [6:0]  id_opcode;
  logic [2:0]  id_funct3;
  logic        id_funct7b5, id_rd_we, id_illegal;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  e_rs1;
    logic [4:0]  e_rs2;
    logic [4:0]  e_rd;
    logic        e_we;
    logic [31:0] e_imm;
    logic        e_ill;
    logic [6:0]  e_op;
    logic [2:0]  e_f3;
    logic        e_f7;
  } vec_t;

  vec_t vecs[14];

  riscv_decode_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .rs1(rs1), .rs2(rs2),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
    .id_opcode(id_opcode), .id_funct3(id_funct3), .id_funct7b5(id_funct7b5),
    .id_rd(id_rd), .id_rd_we(id_rd_we), .id_imm(id_imm), .id_illegal(id_illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] instr,
                               input logic [31:0] pc, input logic rdy, input logic fl);
    @(negedge clk);
    if_valid = v;
    if_instr = instr;
    if_pc    = pc;
    id_ready = rdy;
    flush    = fl;
  endtask

  task automatic checkVec(input vec_t v, input int idx);
    string p;
    p = $sformatf("vec%0d", idx);
    checkOutput({p, ".valid"},   32'(id_valid),    32'd1);
    checkOutput({p, ".pc"},      id_pc,            v.pc);
    checkOutput({p, ".rs1"},     32'(rs1),         32'(v.e_rs1));
    checkOutput({p, ".rs2"},     32'(rs2),         32'(v.e_rs2));
    checkOutput({p, ".rd"},      32'(id_rd),       32'(v.e_rd));
    checkOutput({p, ".rd_we"},   32'(id_rd_we),    32'(v.e_we));
    checkOutput({p, ".imm"},     id_imm,           v.e_imm);
    checkOutput({p, ".illegal"}, 32'(id_illegal),  32'(v.e_ill));
    checkOutput({p, ".opcode"},  32'(id_opcode),   32'(v.e_op));
    checkOutput({p, ".funct3"},  32'(id_funct3),   32'(v.e_f3));
    checkOutput({p, ".funct7b5"},32'(id_funct7b5), 32'(v.e_f7));
  endtask

  initial begin
    //             instr         pc        rs1    rs2    rd     we    imm           ill   op        f3    f7
    vecs[0]  = '{32'hFFF08293, 32'h100, 5'd1,  5'd0,  5'd5,  1'b1, 32'hFFFFFFFF, 1'b0, 7'h13, 3'd0, 1'b1}; // addi x5,x1,-1
    vecs[1]  = '{32'h002081B3, 32'h104, 5'd1,  5'd2,  5'd3,  1'b1, 32'h00000000, 1'b0, 7'h33, 3'd0, 1'b0}; // add x3,x1,x2
    vecs[2]  = '{32'h123453B7, 32'h108, 5'd0,  5'd0,  5'd7,  1'b1, 32'h12345000, 1'b0, 7'h37, 3'd5, 1'b0}; // lui x7,0x12345
    vecs[3]  = '{32'h0020A423, 32'h10C, 5'd1,  5'd2,  5'd0,  1'b0, 32'h00000008, 1'b0, 7'h23, 3'd2, 1'b0}; // sw x2,8(x1)
    vecs[4]  = '{32'hFE208EE3, 32'h110, 5'd1,  5'd2,  5'd0,  1'b0, 32'hFFFFFFFC, 1'b0, 7'h63, 3'd0, 1'b1}; // beq x1,x2,-4
    vecs[5]  = '{32'h001000EF, 32'h114, 5'd0,  5'd0,  5'd1,  1'b1, 32'h00000800, 1'b0, 7'h6F, 3'd0, 1'b0}; // jal x1,2048
    vecs[6]  = '{32'h0041A003, 32'h118, 5'd3,  5'd0,  5'd0,  1'b0, 32'h00000004, 1'b0, 7'h03, 3'd2, 1'b0}; // lw x0,4(x3)
    vecs[7]  = '{32'hFFFFF517, 32'h11C, 5'd0,  5'd0,  5'd10, 1'b1, 32'hFFFFF000, 1'b0, 7'h17, 3'd7, 1'b1}; // auipc x10
    vecs[8]  = '{32'h00000000, 32'h120, 5'd0,  5'd0,  5'd0,  1'b0, 32'h00000000, 1'b1, 7'h00, 3'd0, 1'b0}; // all-zero
    vecs[9]  = '{32'hFFF08291, 32'h124, 5'd0,  5'd0,  5'd0,  1'b0, 32'h00000000, 1'b1, 7'h11, 3'd0, 1'b1}; // low bits 01
    vecs[10] = '{32'h000280E7, 32'h128, 5'd5,  5'd0,  5'd1,  1'b1, 32'h00000000, 1'b0, 7'h67, 3'd0, 1'b0}; // jalr x1,0(x5)
    vecs[11] = '{32'h300022F3, 32'h12C, 5'd0,  5'd0,  5'd0,  1'b0, 32'h00000300, 1'b0, 7'h73, 3'd2, 1'b0}; // csrrs x5,mstatus
    vecs[12] = '{32'h0FF0000F, 32'h130, 5'd0,  5'd0,  5'd0,  1'b0, 32'h000000FF, 1'b0, 7'h0F, 3'd0, 1'b0}; // fence
    vecs[13] = '{32'h41DF0FB3, 32'h134, 5'd30, 5'd29, 5'd31, 1'b1, 32'h00000000, 1'b0, 7'h33, 3'd0, 1'b1}; // sub x31,x30,x29

    rst = 1'b1; flush = 1'b0; if_valid = 1'b0; id_ready = 1'b1;
    if_instr = '0; if_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.valid", 32'(id_valid), 32'd0);
    checkOutput("reset.rs1",   32'(rs1),      32'd0);
    checkOutput("reset.rs2",   32'(rs2),      32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset.if_ready", 32'(if_ready), 32'd1);

    // Stream the whole table back-to-back with execute always ready.
    for (int i = 0; i < 14; i++) begin
      applyStimulus(1'b1, vecs[i].instr, vecs[i].pc, 1'b1, 1'b0);
      #1;
      checkOutput($sformatf("vec%0d.if_ready", i), 32'(if_ready), 32'd1);
      @(posedge clk);
      #1;
      checkVec(vecs[i], i);
    end

    // Drain: valid drops, data fields hold.
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("drain.valid", 32'(id_valid), 32'd0);
    checkOutput("drain.rd",    32'(id_rd),    32'd31);
    checkOutput("drain.pc",    id_pc,         32'h134);

    // Backpressure: ADD held while LUI is offered for three cycles.
    applyStimulus(1'b1, 32'h002081B3, 32'h200, 1'b1, 1'b0);
    @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, 32'h123453B7, 32'h204, 1'b0, 1'b0);
      #1;
      checkOutput($sformatf("stall%0d.if_ready", c), 32'(if_ready), 32'd0);
      @(posedge clk);
      #1;
      checkOutput($sformatf("stall%0d.valid", c), 32'(id_valid), 32'd1);
      checkOutput($sformatf("stall%0d.pc", c),    id_pc,         32'h200);
      checkOutput($sformatf("stall%0d.rs1", c),   32'(rs1),      32'd1);
      checkOutput($sformatf("stall%0d.rs2", c),   32'(rs2),      32'd2);
      checkOutput($sformatf("stall%0d.rd", c),    32'(id_rd),    32'd3);
    end
    applyStimulus(1'b1, 32'h123453B7, 32'h204, 1'b1, 1'b0);
    #1;
    checkOutput("release.if_ready", 32'(if_ready), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("release.pc",  id_pc,      32'h204);
    checkOutput("release.rd",  32'(id_rd), 32'd7);
    checkOutput("release.imm", id_imm,     32'h12345000);

    // Flush while full of ADD, with an ADDI offered that must not land.
    applyStimulus(1'b1, 32'h002081B3, 32'h240, 1'b1, 1'b0);
    @(posedge clk);
    applyStimulus(1'b1, 32'hFFF08293, 32'h300, 1'b0, 1'b1);
    #1;
    checkOutput("flush.if_ready", 32'(if_ready), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("flush.valid", 32'(id_valid), 32'd0);
    checkOutput("flush.rs1",   32'(rs1),      32'd0);
    checkOutput("flush.rs2",   32'(rs2),      32'd0);
    checkOutput("flush.pc",    id_pc,         32'h240);
    checkOutput("flush.rd",    32'(id_rd),    32'd3);

    // Reset during a stall loses the held instruction and zeroes every field.
    applyStimulus(1'b1, 32'hFFF08293, 32'h400, 1'b1, 1'b0);
    @(posedge clk);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rststall.valid", 32'(id_valid), 32'd0);
    checkOutput("rststall.rs1",   32'(rs1),      32'd0);
    checkOutput("rststall.rd",    32'(id_rd),    32'd0);
    checkOutput("rststall.rd_we", 32'(id_rd_we), 32'd0);
    checkOutput("rststall.imm",   id_imm,        32'd0);
    checkOutput("rststall.pc",    id_pc,         32'd0);
    checkOutput("rststall.op",    32'(id_opcode),32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
